// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage data-memory accesses over a req/ack
// handshake, stalls the pipeline while an access is outstanding and runs a
// watchdog that traps into a sticky error state on a missing acknowledge.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] RtData,
    input  logic              RegWrite,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              RegWrite_out,
    output logic [DATA_W-1:0] Mem_r_data,
    output logic              err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_req_d, mem_we_d, err_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_d, mem_r_data_d;
    logic               access_c;

    assign access_c = MemRead | MemWrite;

    // Pipeline freeze and MEM/WB bubble; stall drops in DONE so the pipe advances
    always_comb begin
        stall = 1'b0;
        unique case (state_q)
            ST_IDLE: stall = access_c;
            ST_BUSY: stall = 1'b1;
            ST_ERR:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
        RegWrite_out = RegWrite & ~stall;
    end

    // Next-state and next-output logic; the access type is remembered in mem_we
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_r_data_d = Mem_r_data;
        err_d        = err;
        unique case (state_q)
            ST_IDLE: begin
                // A set MemWrite makes the access a write even if MemRead is also set
                if (access_c) begin
                    state_d     = ST_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWrite;
                    mem_addr_d  = ALUResult;
                    mem_wdata_d = RtData;
                    cnt_d       = '0;
                end
            end
            ST_BUSY: begin
                // An ack on the final watchdog cycle still completes normally
                if (mem_ack) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we) begin
                        mem_r_data_d = mem_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_ERR;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                mem_req_d = 1'b0;
                err_d     = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            Mem_r_data <= '0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            Mem_r_data <= mem_r_data_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vector table for the handshake sequences plus
// hand-written sequences for the watchdog and asynchronous reset.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        MemRead, MemWrite, RegWrite;
    logic [31:0] ALUResult, RtData;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        stall, RegWrite_out, err;
    logic [31:0] Mem_r_data;

    int errors = 0;
    int checks = 0;

    mem_access_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .ALUResult   (ALUResult),
        .RtData      (RtData),
        .RegWrite    (RegWrite),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .stall       (stall),
        .RegWrite_out(RegWrite_out),
        .Mem_r_data  (Mem_r_data),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic        rd, wr, rw;
        logic [31:0] addr, wdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_stall, e_rwo, e_req, e_we;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic        e_err;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    function automatic vec_t v(input logic rd, input logic wr, input logic rw,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic ack, input logic [31:0] rdata,
                               input logic e_stall, input logic e_rwo,
                               input logic e_req, input logic e_we,
                               input logic [31:0] e_addr, input logic [31:0] e_wdata,
                               input logic [31:0] e_rdata, input logic e_err);
        vec_t r;
        r.rd = rd; r.wr = wr; r.rw = rw; r.addr = addr; r.wdata = wdata;
        r.ack = ack; r.rdata = rdata;
        r.e_stall = e_stall; r.e_rwo = e_rwo; r.e_req = e_req; r.e_we = e_we;
        r.e_addr = e_addr; r.e_wdata = e_wdata; r.e_rdata = e_rdata; r.e_err = e_err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic rw,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic ack, input logic [31:0] rdata);
        MemRead = rd; MemWrite = wr; RegWrite = rw;
        ALUResult = addr; RtData = wdata; mem_ack = ack; mem_rdata = rdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        // rd wr rw addr wdata ack rdata | stall rwo req we addr wdata Mem_r_data err
        vecs[0]  = v(0,0,1,32'h0,  32'h0,   0,32'h0,        0,1,0,0,32'h0,  32'h0,   32'h0,        0);
        vecs[1]  = v(1,0,1,32'h40, 32'h0,   0,32'h0,        1,0,0,0,32'h0,  32'h0,   32'h0,        0);
        vecs[2]  = v(1,0,1,32'h40, 32'h0,   0,32'h0,        1,0,1,0,32'h40, 32'h0,   32'h0,        0);
        vecs[3]  = v(1,0,1,32'h40, 32'h0,   0,32'h0,        1,0,1,0,32'h40, 32'h0,   32'h0,        0);
        vecs[4]  = v(1,0,1,32'h40, 32'h0,   0,32'h0,        1,0,1,0,32'h40, 32'h0,   32'h0,        0);
        vecs[5]  = v(1,0,1,32'h40, 32'h0,   1,32'hDEADBEEF, 1,0,1,0,32'h40, 32'h0,   32'h0,        0);
        vecs[6]  = v(1,0,1,32'h40, 32'h0,   0,32'h0,        0,1,0,0,32'h40, 32'h0,   32'hDEADBEEF, 0);
        vecs[7]  = v(0,0,0,32'h0,  32'h0,   0,32'h0,        0,0,0,0,32'h40, 32'h0,   32'hDEADBEEF, 0);
        vecs[8]  = v(0,1,0,32'h80, 32'h1234,0,32'h0,        1,0,0,0,32'h40, 32'h0,   32'hDEADBEEF, 0);
        vecs[9]  = v(0,1,0,32'h80, 32'h1234,1,32'hBADBAD00, 1,0,1,1,32'h80, 32'h1234,32'hDEADBEEF, 0);
        vecs[10] = v(0,1,0,32'h80, 32'h1234,0,32'h0,        0,0,0,1,32'h80, 32'h1234,32'hDEADBEEF, 0);
        vecs[11] = v(1,0,1,32'h100,32'h0,   0,32'h0,        1,0,0,1,32'h80, 32'h1234,32'hDEADBEEF, 0);
        vecs[12] = v(1,0,1,32'h100,32'h0,   1,32'h11111111, 1,0,1,0,32'h100,32'h0,   32'hDEADBEEF, 0);
        vecs[13] = v(1,0,1,32'h100,32'h0,   0,32'h0,        0,1,0,0,32'h100,32'h0,   32'h11111111, 0);
        vecs[14] = v(1,0,1,32'h104,32'h0,   0,32'h0,        1,0,0,0,32'h100,32'h0,   32'h11111111, 0);
        vecs[15] = v(1,0,1,32'h104,32'h0,   1,32'h22222222, 1,0,1,0,32'h104,32'h0,   32'h11111111, 0);
        vecs[16] = v(1,0,1,32'h104,32'h0,   0,32'h0,        0,1,0,0,32'h104,32'h0,   32'h22222222, 0);
        vecs[17] = v(0,0,1,32'h0,  32'h0,   1,32'h0000CAFE, 0,1,0,0,32'h104,32'h0,   32'h22222222, 0);
        vecs[18] = v(1,1,0,32'h200,32'hABCD,0,32'h0,        1,0,0,0,32'h104,32'h0,   32'h22222222, 0);
        vecs[19] = v(1,1,0,32'h200,32'hABCD,0,32'h0,        1,0,1,1,32'h200,32'hABCD,32'h22222222, 0);
        vecs[20] = v(1,1,0,32'h200,32'hABCD,1,32'h33333333, 1,0,1,1,32'h200,32'hABCD,32'h22222222, 0);
        vecs[21] = v(1,1,0,32'h200,32'hABCD,0,32'h0,        0,0,0,1,32'h200,32'hABCD,32'h22222222, 0);
        vecs[22] = v(0,0,1,32'h0,  32'h0,   0,32'h0,        0,1,0,1,32'h200,32'hABCD,32'h22222222, 0);

        step();
        step();
        rst_n = 1'b1;

        // Table: load with late ack, store, back-to-back loads, stray ack, dual-flag write
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].rw, vecs[i].addr, vecs[i].wdata,
                  vecs[i].ack, vecs[i].rdata);
            #1;
            chk($sformatf("v%0d.stall", i),      32'(stall),        32'(vecs[i].e_stall));
            chk($sformatf("v%0d.RegWrite_out", i), 32'(RegWrite_out), 32'(vecs[i].e_rwo));
            chk($sformatf("v%0d.mem_req", i),    32'(mem_req),      32'(vecs[i].e_req));
            chk($sformatf("v%0d.mem_we", i),     32'(mem_we),       32'(vecs[i].e_we));
            chk($sformatf("v%0d.mem_addr", i),   mem_addr,          vecs[i].e_addr);
            chk($sformatf("v%0d.mem_wdata", i),  mem_wdata,         vecs[i].e_wdata);
            chk($sformatf("v%0d.Mem_r_data", i), Mem_r_data,        vecs[i].e_rdata);
            chk($sformatf("v%0d.err", i),        32'(err),          32'(vecs[i].e_err));
            step();
        end

        // Timeout: ack never arrives, ERR after 16 BUSY cycles
        drive(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 1'b0, 32'h0);
        step();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to.busy%0d.mem_req", i), 32'(mem_req), 32'd1);
            chk($sformatf("to.busy%0d.err", i),     32'(err),     32'd0);
            chk($sformatf("to.busy%0d.stall", i),   32'(stall),   32'd1);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, (i == 1) ? 1'b1 : 1'b0, 32'hFFFF0000);
            #1;
            chk($sformatf("to.err%0d.err", i),          32'(err),          32'd1);
            chk($sformatf("to.err%0d.mem_req", i),      32'(mem_req),      32'd0);
            chk($sformatf("to.err%0d.stall", i),        32'(stall),        32'd1);
            chk($sformatf("to.err%0d.RegWrite_out", i), 32'(RegWrite_out), 32'd0);
            step();
        end
        rst_n = 1'b0;
        #2;
        chk("to.rst.err",   32'(err),   32'd0);
        chk("to.rst.stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        step();

        // Ack on the last watchdog cycle completes normally
        drive(1'b1, 1'b0, 1'b1, 32'h310, 32'h0, 1'b0, 32'h0);
        step();
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("late.busy%0d.mem_req", i), 32'(mem_req), 32'd1);
            step();
        end
        drive(1'b1, 1'b0, 1'b1, 32'h310, 32'h0, 1'b1, 32'h5A5A5A5A);
        #1;
        chk("late.busy15.mem_req", 32'(mem_req), 32'd1);
        step();
        drive(1'b1, 1'b0, 1'b1, 32'h310, 32'h0, 1'b0, 32'h0);
        #1;
        chk("late.done.err",        32'(err),          32'd0);
        chk("late.done.stall",      32'(stall),        32'd0);
        chk("late.done.mem_req",    32'(mem_req),      32'd0);
        chk("late.done.Mem_r_data", Mem_r_data,        32'h5A5A5A5A);
        chk("late.done.RegWrite",   32'(RegWrite_out), 32'd1);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        step();

        // Asynchronous reset between edges while BUSY
        drive(1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 1'b0, 32'h0);
        step();
        step();
        chk("ar.pre.mem_req", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("ar.mem_req",    32'(mem_req), 32'd0);
        chk("ar.err",        32'(err),     32'd0);
        chk("ar.Mem_r_data", Mem_r_data,   32'h0);
        chk("ar.mem_addr",   mem_addr,     32'h0);
        chk("ar.stall",      32'(stall),   32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar.idle.mem_req", 32'(mem_req), 32'd0);
        chk("ar.idle.stall",   32'(stall),   32'd0);
        drive(1'b1, 1'b0, 1'b1, 32'h404, 32'h0, 1'b0, 32'h0);
        #1;
        chk("ar.new.stall",   32'(stall),   32'd1);
        chk("ar.new.mem_req", 32'(mem_req), 32'd0);
        step();
        chk("ar.new.busy_req",  32'(mem_req), 32'd1);
        chk("ar.new.busy_addr", mem_addr,     32'h404);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences the MEM stage's data-memory access against a variable-latency memory with a req/ack handshake.
- While an access is outstanding it freezes the upstream pipeline registers and feeds a bubble (RegWrite gated to 0) into MEM/WB.
- On completion it presents the captured load data for MEM/WB to latch.
- A watchdog flags memories that never acknowledge.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, data width.
- TIMEOUT, 16, max cycles in BUSY without mem_ack before entering ERR (legal range 2..255).

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  asynchronous active-low reset.
- MemRead  input  1  EX/MEM load flag.
- MemWrite  input  1  EX/MEM store flag.
- ALUResult  input  ADDR_W  EX/MEM effective address.
- RtData  input  DATA_W  EX/MEM store data.
- RegWrite  input  1  EX/MEM RegWrite.
- mem_req  output  1  request to data memory, registered.
- mem_we  output  1  1 = write, registered.
- mem_addr  output  ADDR_W  registered address.
- mem_wdata  output  DATA_W  registered write data.
- mem_rdata  input  DATA_W  read data, valid when mem_ack=1.
- mem_ack  input  1  one-cycle completion pulse.
- stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- RegWrite_out  output  1  RegWrite forwarded to MEM/WB, equal to RegWrite & ~stall.
- Mem_r_data  output  DATA_W  captured load data to MEM/WB.
- err  output  1  sticky timeout flag.

Behaviour:
- Clock and reset
  - State updates on posedge clk, so outputs settle before the pipeline registers' negedge capture.
  - rst_n low, at any time including mid-access: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, Mem_r_data=0, err=0, counter=0.
- States: IDLE, BUSY, DONE, ERR.
- IDLE
  - access = MemRead | MemWrite.
  - If access: on the next posedge go to BUSY, mem_req=1, mem_we=MemWrite, latch mem_addr=ALUResult and mem_wdata=RtData, counter=0.
  - If MemRead and MemWrite are both 1, the access is a write.
  - mem_ack in IDLE is ignored.
- BUSY
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack is sampled high.
  - On mem_ack: go to DONE, mem_req=0, and Mem_r_data=mem_rdata if the access was a read. A write leaves Mem_r_data unchanged.
  - Without mem_ack: counter increments. When counter==TIMEOUT-1 and mem_ack=0, go to ERR, mem_req=0, err=1.
  - mem_ack arriving in the same cycle counter reaches TIMEOUT-1 wins: go to DONE, not ERR.
- DONE
  - Lasts exactly 1 cycle, then return to IDLE.
  - No new access is accepted in DONE; the next instruction is evaluated in IDLE.
- ERR
  - Terminal until reset. mem_req=0, err=1, stall=1.
- stall (combinational)
  - stall = (IDLE & access) | BUSY | ERR.
  - stall is 0 in DONE, so the pipeline advances at that cycle's negedge.
- Latency and throughput
  - Minimum access = 3 cycles: IDLE detect, BUSY with same-cycle ack, DONE.
  - Back-to-back accesses each pay the full sequence.
- Non-memory instructions in IDLE: stall=0, RegWrite_out=RegWrite, zero added latency.
- Mem_r_data holds its last captured value until the next read completes.

Test Plan:
- Load, addr 0x40, mem_ack 3 cycles after mem_req rises, mem_rdata=0xDEADBEEF:
  - stall high 5 cycles (IDLE + 4 BUSY).
  - RegWrite_out=0 throughout.
  - DONE cycle: stall=0, Mem_r_data=0xDEADBEEF.
- Store, addr 0x80, data 0x1234, mem_ack in the first BUSY cycle:
  - mem_we=1, mem_addr=0x80, mem_wdata=0x1234 while mem_req=1.
  - DONE next cycle.
  - Mem_r_data unchanged.
- Two consecutive loads, each with 1-cycle ack: two separate req pulses, one DONE cycle between them, each load's data captured in order.
- TIMEOUT=16, load with mem_ack never asserted:
  - ERR entered after 16 BUSY cycles.
  - mem_req=0, err=1, stall stays 1 until rst_n pulses low.
  - Variant: ack at BUSY cycle 16 goes to DONE instead.
- rst_n driven low mid-BUSY, asynchronously between edges: mem_req, err and Mem_r_data are 0 immediately; state is IDLE after release.
- mem_ack pulsed in IDLE with no access, plus MemRead=MemWrite=1:
  - The stray ack is ignored.
  - The simultaneous-flag access is issued as a write (mem_we=1).
